// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of {pc, instr} pairs
// with valid/ready on both sides, first-word-fall-through head and flush.
module fetch_queue #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_flag,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // Flush wins over both handshakes in the same cycle.
    assign push = in_valid & in_ready & ~flush_flag;
    assign pop  = out_valid & out_ready & ~flush_flag;

    assign out_pc    = empty ? '0 : pc_mem[rd_ptr];
    assign out_instr = empty ? XLEN'(NOP_INSTR) : instr_mem[rd_ptr];

    // Storage needs no reset; empty masks stale contents on the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_flag) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: reset, fill, drain, streaming wrap,
// flush and asynchronous reset mid-stream.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_flag;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .flush_flag (flush_flag),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA5000000 | pc;
    endfunction

    initial begin
        rst        = 1'b0;
        flush_flag = 1'b0;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_instr   = '0;
        out_ready  = 1'b0;

        // Reset
        #22;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_count",     {29'd0, count},     32'd0);
        chk("rst_out_instr", out_instr,          NOP);
        chk("rst_out_pc",    out_pc,             32'd0);
        chk("rst_empty",     {31'd0, empty},     32'd1);
        chk("rst_full",      {31'd0, full},      32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_count", {29'd0, count}, 32'd0);

        // Fill
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_pc    = 32'(i * 4);
            in_instr = instr_of(32'(i * 4));
            step();
            chk("fill_count", {29'd0, count}, 32'(i + 1));
            chk("fill_head",  out_pc,         32'h0);
        end
        chk("fill_full",     {31'd0, full},     32'd1);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        in_pc    = 32'h10;
        in_instr = instr_of(32'h10);
        step();
        chk("ovf_count", {29'd0, count}, 32'd4);
        chk("ovf_head",  out_pc,         32'h0);

        // Drain in order
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",    out_pc,    32'(i * 4));
            chk("drain_instr", out_instr, instr_of(32'(i * 4)));
            step();
        end
        chk("drain_empty",     {31'd0, empty},     32'd1);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_nop",       out_instr,          NOP);
        chk("drain_pc_zero",   out_pc,             32'd0);

        // Streaming with wrap: 16 instructions through a depth-4 queue
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_pc    = 32'(k * 4);
            in_instr = instr_of(32'(k * 4));
            step();
            chk("stream_count", {29'd0, count}, 32'd1);
            chk("stream_pc",    out_pc,         32'(k * 4));
            chk("stream_instr", out_instr,      instr_of(32'(k * 4)));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_empty", {31'd0, empty}, 32'd1);

        // Flush with 3 entries queued and a push offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc    = 32'h100 + 32'(i * 4);
            in_instr = instr_of(in_pc);
            step();
        end
        chk("pre_flush_count", {29'd0, count}, 32'd3);
        chk("pre_flush_head",  out_pc,         32'h100);
        flush_flag = 1'b1;
        out_ready  = 1'b1;
        in_pc      = 32'h80;
        in_instr   = instr_of(32'h80);
        step();
        flush_flag = 1'b0;
        out_ready  = 1'b0;
        chk("flush_count",     {29'd0, count},     32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
        in_pc    = 32'h200;
        in_instr = instr_of(32'h200);
        step();
        chk("post_flush_pc",    out_pc,         32'h200);
        chk("post_flush_instr", out_instr,      instr_of(32'h200));
        chk("post_flush_count", {29'd0, count}, 32'd1);

        // Asynchronous reset between edges with 2 entries queued
        in_pc    = 32'h204;
        in_instr = instr_of(32'h204);
        step();
        in_valid = 1'b0;
        chk("pre_arst_count", {29'd0, count}, 32'd2);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_count",     {29'd0, count},     32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_instr", out_instr,          NOP);
        chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
        #2;
        rst = 1'b1;
        step();
        chk("post_arst_empty", {31'd0, empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
